pwrbtn_pulse_gen: RTL and testbench

Generates clean, timed active-low button-press pulses for power-sequence control outputs, such as a virtual power button toward the chipset. It is the transmit-side counterpart of the input debounce path. A short or long press is requested with a single-cycle strobe. The block then drives the output low for a tick-accurate duration and enforces a release hold-off, so that a debouncing receiver always sees a stable, well-separated press. It sits in the power-sequence logic between the sequencing state machines and the output pin registers.

---
 rtl/pwrbtn_pulse_gen_if.sv | 22 ++
 rtl/pwrbtn_pulse_gen.sv | 103 ++++++++++
 tb/tb_pwrbtn_pulse_gen.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pwrbtn_pulse_gen_if.sv
// Request/status bundle between a power-sequencing FSM (master) and the
// button pulse generator (slave).
interface pwrbtn_pulse_gen_if;
  logic tick_en;
  logic req_short;
  logic req_long;
  logic abort;
  logic btn_n_out;
  logic busy;
  logic done;
  logic req_drop;

  modport master (
    output tick_en, req_short, req_long, abort,
    input  btn_n_out, busy, done, req_drop
  );

  modport slave (
    input  tick_en, req_short, req_long, abort,
    output btn_n_out, busy, done, req_drop
  );
endinterface

// File: rtl/pwrbtn_pulse_gen.sv
// Timed active-low button press generator: a request drives btn_n_out low for a
// tick-accurate duration, then enforces a released hold-off before the next press.
module pwrbtn_pulse_gen #(
  parameter int unsigned TICK_DIV    = 33,
  parameter int unsigned SHORT_TICKS = 200,
  parameter int unsigned LONG_TICKS  = 4000,
  parameter int unsigned GAP_TICKS   = 40,
  parameter int unsigned CNT_W       = 13
) (
  input logic               clk,
  input logic               rst_n,
  pwrbtn_pulse_gen_if.slave bus
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  ShortLast = CNT_W'(SHORT_TICKS - 1);
  localparam logic [CNT_W-1:0]  LongLast  = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0]  GapLast   = CNT_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StAssert, StHoldoff} state_e;

  state_e            state_q;
  logic [PrescW-1:0] presc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  target_last_q;
  logic              btn_q;
  logic              drop_q;

  logic tick;
  logic req_any;
  logic assert_last;
  logic gap_last;
  logic busy;

  assign tick        = bus.tick_en && (presc_q == PrescLast);
  assign req_any     = bus.req_short | bus.req_long;
  assign assert_last = (state_q == StAssert) && tick && (cnt_q == target_last_q);
  assign gap_last    = (state_q == StHoldoff) && tick && (cnt_q == GapLast);
  // busy drops in the completing cycle so a request there is accepted, not dropped.
  assign busy        = (state_q != StIdle) && !gap_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      presc_q       <= '0;
      cnt_q         <= '0;
      target_last_q <= '0;
      btn_q         <= 1'b1;
      drop_q        <= 1'b0;
    end else begin
      drop_q <= req_any && busy;
      unique case (state_q)
        StIdle: begin
          if (req_any) begin
            state_q       <= StAssert;
            target_last_q <= bus.req_long ? LongLast : ShortLast;
            presc_q       <= '0;
            cnt_q         <= '0;
            btn_q         <= 1'b0;
          end
        end
        StAssert: begin
          if (bus.tick_en) begin
            // Abort wins over a terminal tick landing in the same cycle.
            if (bus.abort || assert_last) begin
              state_q <= StHoldoff;
              presc_q <= '0;
              cnt_q   <= '0;
              btn_q   <= 1'b1;
            end else begin
              presc_q <= tick ? '0 : presc_q + PrescW'(1);
              if (tick) cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        StHoldoff: begin
          if (gap_last) begin
            presc_q <= '0;
            cnt_q   <= '0;
            if (req_any) begin
              state_q       <= StAssert;
              target_last_q <= bus.req_long ? LongLast : ShortLast;
              btn_q         <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end else if (bus.tick_en) begin
            presc_q <= tick ? '0 : presc_q + PrescW'(1);
            if (tick) cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.btn_n_out = btn_q;
  assign bus.busy      = busy;
  assign bus.done      = gap_last;
  assign bus.req_drop  = drop_q;

endmodule

// File: tb/tb_pwrbtn_pulse_gen.sv
// Bench for pwrbtn_pulse_gen: directed press scenarios plus random traffic,
// checked every cycle against a remaining-cycles reference model.
module tb_pwrbtn_pulse_gen;

  localparam int unsigned TD    = 4;
  localparam int unsigned SHORT = 3;
  localparam int unsigned LONG  = 6;
  localparam int unsigned GAP   = 2;

  logic clk = 1'b0;
  logic rst_n;

  pwrbtn_pulse_gen_if bus ();

  pwrbtn_pulse_gen #(
    .TICK_DIV   (TD),
    .SHORT_TICKS(SHORT),
    .LONG_TICKS (LONG),
    .GAP_TICKS  (GAP),
    .CNT_W      (13)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: phase 0 idle, 1 pressed, 2 hold-off; rem = enabled cycles left in phase.
  int   m_phase;
  int   m_rem;
  logic m_btn;
  logic m_drop;

  logic obs_btn, obs_busy, obs_done, obs_drop;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_rem   = 0;
    m_btn   = 1'b1;
    m_drop  = 1'b0;
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, then advance the model.
  task automatic cycle(input logic ts, input logic rs, input logic rl, input logic ab);
    logic e_done, e_busy, req;
    bus.tick_en   = ts;
    bus.req_short = rs;
    bus.req_long  = rl;
    bus.abort     = ab;
    @(negedge clk);
    e_done = (m_phase == 2) && ts && (m_rem == 1);
    e_busy = (m_phase != 0) && !e_done;
    obs_btn  = bus.btn_n_out;
    obs_busy = bus.busy;
    obs_done = bus.done;
    obs_drop = bus.req_drop;
    chk("btn_n_out", 32'(obs_btn), 32'(m_btn));
    chk("busy", 32'(obs_busy), 32'(e_busy));
    chk("done", 32'(obs_done), 32'(e_done));
    chk("req_drop", 32'(obs_drop), 32'(m_drop));
    @(posedge clk);
    req    = rs | rl;
    m_drop = req && e_busy;
    case (m_phase)
      0: if (req) begin
        m_phase = 1;
        m_rem   = int'(rl ? LONG : SHORT) * int'(TD);
        m_btn   = 1'b0;
      end
      1: if (ts) begin
        m_rem--;
        if (ab || m_rem == 0) begin
          m_phase = 2;
          m_rem   = int'(GAP * TD);
          m_btn   = 1'b1;
        end
      end
      default: if (ts) begin
        m_rem--;
        if (m_rem == 0) begin
          if (req) begin
            m_phase = 1;
            m_rem   = int'(rl ? LONG : SHORT) * int'(TD);
            m_btn   = 1'b0;
          end else begin
            m_phase = 0;
          end
        end
      end
    endcase
    #1;
  endtask

  // Follows a just-accepted press: counts low cycles, then released cycles up to done.
  task automatic measure(input int ab_at, input int fz_at, input int fz_len,
                         input int rq1, input int rq2, input int rq3,
                         output int lo, output int hi, output int drops);
    int k = 0;
    logic ts, rs, ab;
    lo = 0; hi = 0; drops = 0;
    for (int g = 0; g < 500; g++) begin
      ts = !(k >= fz_at && k < fz_at + fz_len);
      rs = (k == rq1) || (k == rq2) || (k == rq3);
      ab = (ab_at >= 0) && (k == ab_at || k == ab_at + 3);
      cycle(ts, rs, 1'b0, ab);
      k++;
      drops += int'(obs_drop);
      if (obs_btn) break;
      lo++;
    end
    hi = 1;
    for (int g = 0; g < 500 && !obs_done; g++) begin
      ts = !(k >= fz_at && k < fz_at + fz_len);
      rs = (k == rq1) || (k == rq2) || (k == rq3);
      ab = (ab_at >= 0) && (k == ab_at || k == ab_at + 3);
      cycle(ts, rs, 1'b0, ab);
      k++;
      drops += int'(obs_drop);
      hi++;
    end
  endtask

  int lo, hi, drops, dones;

  initial begin
    rst_n = 1'b0;
    bus.tick_en = 1'b1; bus.req_short = 1'b0; bus.req_long = 1'b0; bus.abort = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset btn_n_out", 32'(bus.btn_n_out), 32'd1);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset req_drop", 32'(bus.req_drop), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Short press.
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    measure(-1, -1, 0, -1, -1, -1, lo, hi, drops);
    chk("short low cycles", 32'(lo), 32'd12);
    chk("short holdoff cycles", 32'(hi), 32'd8);
    chk("short busy at done", 32'(obs_busy), 32'd0);

    // Long wins over short.
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    measure(-1, -1, 0, -1, -1, -1, lo, hi, drops);
    chk("priority low cycles", 32'(lo), 32'd24);
    chk("priority holdoff cycles", 32'(hi), 32'd8);

    // Abort in the 5th low cycle, second abort lands in hold-off.
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    measure(4, -1, 0, -1, -1, -1, lo, hi, drops);
    chk("abort low cycles", 32'(lo), 32'd5);
    chk("abort holdoff cycles", 32'(hi), 32'd8);

    // Overlapping requests dropped; request in the done cycle accepted.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    measure(-1, -1, 0, 3, 14, 19, lo, hi, drops);
    chk("overlap low cycles", 32'(lo), 32'd12);
    chk("overlap holdoff cycles", 32'(hi), 32'd8);
    chk("overlap drop pulses", 32'(drops), 32'd2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("done-cycle request accepted", 32'(obs_btn), 32'd0);
    measure(-1, -1, 0, -1, -1, -1, lo, hi, drops);
    chk("back-to-back low cycles", 32'(lo), 32'd11);

    // Freeze ticks for 10 cycles mid press.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    measure(-1, 5, 10, -1, -1, -1, lo, hi, drops);
    chk("freeze low cycles", 32'(lo), 32'd22);
    chk("freeze holdoff cycles", 32'(hi), 32'd8);

    // Reset mid press.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (7) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async reset btn_n_out", 32'(bus.btn_n_out), 32'd1);
    chk("async reset busy", 32'(bus.busy), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      dones += int'(obs_done);
    end
    chk("no done after reset", 32'(dones), 32'd0);
    chk("idle after reset", 32'(obs_busy), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 8) != 0, ($urandom % 10) == 0, ($urandom % 25) == 0,
            ($urandom % 30) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
